// File: rtl/axis_orthogonal_merge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_ortho_pkg
//  Brief    : Shared types and helpers for the orthogonal AXI-Stream merge.
//  Revision : 1.0 - initial release
// ============================================================================
package axis_ortho_pkg;

    localparam int ORTHO_MAX_NUM = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } ortho_merge_state_e;

    // Returns the lowest set index, or 0 when no bit is set.
    function automatic int unsigned ortho_lowest_idx(input logic [ORTHO_MAX_NUM-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = ORTHO_MAX_NUM - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_orthogonal_merge_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_stream_inf
//  Brief    : AXI-Stream bundle with master/slaver modports.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_stream_inf #(
    parameter int DSIZE = 8,
    parameter int KSIZE = (DSIZE + 7) / 8,
    parameter int USIZE = 1
) ();
    logic             axis_tvalid;
    logic             axis_tready;
    logic [DSIZE-1:0] axis_tdata;
    logic [KSIZE-1:0] axis_tkeep;
    logic [USIZE-1:0] axis_tuser;
    logic             axis_tlast;

    modport master (
        output axis_tvalid, axis_tdata, axis_tkeep, axis_tuser, axis_tlast,
        input  axis_tready
    );

    modport slaver (
        input  axis_tvalid, axis_tdata, axis_tkeep, axis_tuser, axis_tlast,
        output axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_orthogonal_merge_skid.sv
`default_nettype none
// ============================================================================
//  Module   : axis_ortho_skid
//  Brief    : Two-entry register slice with registered input-side ready.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_ortho_skid #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_s_valid,
    output logic                  o_s_ready,
    input  wire logic [WIDTH-1:0] i_s_payload,
    output logic                  o_m_valid,
    input  wire logic             i_m_ready,
    output logic [WIDTH-1:0]      o_m_payload,
    output logic                  o_full
);
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    assign push = i_s_valid & ready_q;
    assign pop  = (count_q != 2'd0) & i_m_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = i_s_payload;
                else                 tail_d = i_s_payload;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = i_s_payload;
                end else begin
                    head_d = tail_q;
                    tail_d = i_s_payload;
                end
            end
            default: ;
        endcase
        ready_d = (count_d != 2'd2);
    end

    // Ready stays low while in reset so no channel is handshaken before release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    assign o_s_ready   = ready_q;
    assign o_m_valid   = (count_q != 2'd0);
    assign o_m_payload = head_q;
    assign o_full      = (count_q == 2'd2);

endmodule
`default_nettype wire

// File: rtl/axis_orthogonal_merge.sv
`default_nettype none
// ============================================================================
//  Module   : axis_orthogonal_merge
//  Brief    : Frame-locked merge of NUM exclusive AXI-Stream channels with a
//             source-index tag. Optional macro AXIS_ORTHO_MERGE_COLLISION_EN
//             enables the exclusivity-violation pulse on `collision`.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_orthogonal_merge
    import axis_ortho_pkg::*;
#(
    parameter int NUM    = 8,
    parameter int IDSIZE = $clog2(NUM)
) (
    input  wire logic         aclk,
    input  wire logic         aresetn,
    axi_stream_inf.slaver     s00 [NUM-1:0],
    axi_stream_inf.master     m00,
    output logic [IDSIZE-1:0] src_id,
    output logic              collision
);
    localparam int DSIZE = m00.DSIZE;
    localparam int KSIZE = m00.KSIZE;
    localparam int USIZE = m00.USIZE;
    localparam int PW    = IDSIZE + USIZE + KSIZE + 1 + DSIZE;

    logic [NUM-1:0]   ch_valid, ch_last, ch_ready;
    logic [DSIZE-1:0] ch_data [NUM];
    logic [KSIZE-1:0] ch_keep [NUM];
    logic [USIZE-1:0] ch_user [NUM];

    for (genvar g = 0; g < NUM; g++) begin : g_ch
        assign ch_valid[g]        = s00[g].axis_tvalid;
        assign ch_last[g]         = s00[g].axis_tlast;
        assign ch_data[g]         = s00[g].axis_tdata;
        assign ch_keep[g]         = s00[g].axis_tkeep;
        assign ch_user[g]         = s00[g].axis_tuser;
        assign s00[g].axis_tready = ch_ready[g];
    end

    ortho_merge_state_e state_q, state_d;
    logic [IDSIZE-1:0]  lock_id_q, lock_id_d;
    logic [IDSIZE-1:0]  cand_id;
    logic               cand_valid, push, space;
    logic               skid_s_ready, skid_full, skid_m_valid;
    logic [PW-1:0]      in_payload, out_payload;

    assign space = skid_s_ready & ~skid_full;

    always_comb begin
        cand_id    = (state_q == LOCK) ? lock_id_q
                   : IDSIZE'(ortho_lowest_idx(ORTHO_MAX_NUM'(ch_valid)));
        cand_valid = ch_valid[cand_id];
        push       = space & cand_valid;
        // The locked owner keeps tready even while its tvalid is low mid-frame.
        ch_ready   = '0;
        if (space && ((state_q == LOCK) || cand_valid)) ch_ready[cand_id] = 1'b1;

        state_d   = state_q;
        lock_id_d = lock_id_q;
        if (push) begin
            case (state_q)
                IDLE: if (!ch_last[cand_id]) begin
                    state_d   = LOCK;
                    lock_id_d = cand_id;
                end
                LOCK: if (ch_last[cand_id]) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign in_payload = {cand_id, ch_user[cand_id], ch_keep[cand_id],
                         ch_last[cand_id], ch_data[cand_id]};

    axis_ortho_skid #(.WIDTH(PW)) u_skid (
        .clk         (aclk),
        .rst_n       (aresetn),
        .i_s_valid   (cand_valid),
        .o_s_ready   (skid_s_ready),
        .i_s_payload (in_payload),
        .o_m_valid   (skid_m_valid),
        .i_m_ready   (m00.axis_tready),
        .o_m_payload (out_payload),
        .o_full      (skid_full)
    );

    assign m00.axis_tvalid = skid_m_valid;
    assign {src_id, m00.axis_tuser, m00.axis_tkeep, m00.axis_tlast, m00.axis_tdata} = out_payload;

`ifdef AXIS_ORTHO_MERGE_COLLISION_EN
    logic           collision_q, collision_d;
    logic [NUM-1:0] others;

    always_comb begin
        others             = ch_valid;
        others[lock_id_q]  = 1'b0;
        collision_d        = (state_q == IDLE) ? ((ch_valid & (ch_valid - NUM'(1))) != '0)
                                               : (|others);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) collision_q <= 1'b0;
        else          collision_q <= collision_d;
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_orthogonal_merge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_orthogonal_merge
//  Brief    : Self-checking bench: per-cycle scoreboard plus directed literals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_orthogonal_merge;
    localparam int NUM = 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_stream_inf #(.DSIZE(8)) s_if [NUM-1:0] ();
    axi_stream_inf #(.DSIZE(8)) m_if ();

    logic [2:0]     src_id;
    logic           collision;
    logic [NUM-1:0] drv_valid = '0;
    logic [NUM-1:0] drv_last  = '0;
    logic [NUM-1:0] mon_ready;
    logic [7:0]     drv_data [NUM];
    logic           m_ready = 1'b1;

    for (genvar g = 0; g < NUM; g++) begin : g_drv
        assign s_if[g].axis_tvalid = drv_valid[g];
        assign s_if[g].axis_tdata  = drv_data[g];
        assign s_if[g].axis_tlast  = drv_last[g];
        assign s_if[g].axis_tkeep  = 1'b1;
        assign s_if[g].axis_tuser  = 1'b0;
        assign mon_ready[g]        = s_if[g].axis_tready;
    end
    assign m_if.axis_tready = m_ready;

    axis_orthogonal_merge #(.NUM(NUM)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s00       (s_if),
        .m00       (m_if),
        .src_id    (src_id),
        .collision (collision)
    );

    typedef struct packed { logic [7:0] data; logic last; } beat_t;
    typedef struct packed { logic [7:0] data; logic last; int ch; int cyc; } rec_t;

    beat_t chq [NUM][$];
    rec_t  exp_q[$];
    rec_t  out_log[$];
    rec_t  acc_log[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int armed = 0;
    int owner = -1;
    int coll_seen = 0;
    bit rand_ready = 0;
    bit pause [NUM];
    bit fire  [NUM];
    logic coll_cond = 1'b0;
    logic coll_exp  = 1'b0;
    logic stall_prev = 1'b0;
    logic [63:0] prev_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle model: grant rules, skid occupancy and output order.
    task automatic check_cycle();
        int allowed;
        logic [NUM-1:0] exp_rdy;
        rec_t e;
        for (int i = 0; i < NUM; i++) fire[i] = 0;
        if (!aresetn) begin
            chk("rst_m_tvalid", {63'd0, m_if.axis_tvalid}, 64'd0);
            chk("rst_s_tready", {56'd0, mon_ready}, 64'd0);
            chk("rst_src_id", {61'd0, src_id}, 64'd0);
            chk("rst_collision", {63'd0, collision}, 64'd0);
            exp_q.delete();
            owner = -1; armed = 0; coll_cond = 1'b0; stall_prev = 1'b0;
            return;
        end
        allowed = owner;
        if (owner < 0)
            for (int i = NUM - 1; i >= 0; i--) if (drv_valid[i]) allowed = i;
        exp_rdy = '0;
        if (allowed >= 0 && armed > 0 && exp_q.size() < 2) exp_rdy[allowed] = 1'b1;
        chk("s_tready", {56'd0, mon_ready}, {56'd0, exp_rdy});
        chk("m_tvalid", {63'd0, m_if.axis_tvalid}, {63'd0, exp_q.size() != 0});
        chk("collision", {63'd0, collision}, {63'd0, coll_exp});
        if (collision === 1'b1) coll_seen++;
        if (stall_prev)
            chk("stall_hold", {51'd0, m_if.axis_tvalid, m_if.axis_tdata, m_if.axis_tlast, src_id},
                prev_out);
        if (m_if.axis_tvalid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {56'd0, m_if.axis_tdata}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {56'd0, m_if.axis_tdata}, {56'd0, e.data});
                chk("out_last", {63'd0, m_if.axis_tlast}, {63'd0, e.last});
                chk("out_src_id", {61'd0, src_id}, 64'(e.ch));
                out_log.push_back('{m_if.axis_tdata, m_if.axis_tlast, int'(src_id), cyc});
            end
        end
        stall_prev = m_if.axis_tvalid && !m_ready;
        prev_out   = {51'd0, m_if.axis_tvalid, m_if.axis_tdata, m_if.axis_tlast, src_id};
`ifdef AXIS_ORTHO_MERGE_COLLISION_EN
        if (owner < 0) coll_cond = ($countones(drv_valid) > 1);
        else           coll_cond = |(drv_valid & ~(NUM'(1) << owner));
`else
        coll_cond = 1'b0;
`endif
        for (int i = 0; i < NUM; i++) begin
            if (drv_valid[i] && mon_ready[i]) begin
                fire[i] = 1;
                exp_q.push_back('{drv_data[i], drv_last[i], i, cyc});
                acc_log.push_back('{drv_data[i], drv_last[i], i, cyc});
                if (owner < 0 && !drv_last[i]) owner = i;
                else if (owner >= 0 && drv_last[i]) owner = -1;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM; i++) begin
            if (fire[i] && chq[i].size() > 0) void'(chq[i].pop_front());
            fire[i] = 0;
            drv_valid[i] = (chq[i].size() > 0) && !pause[i];
            drv_data[i]  = (chq[i].size() > 0) ? chq[i][0].data : 8'h00;
            drv_last[i]  = (chq[i].size() > 0) ? chq[i][0].last : 1'b0;
        end
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) begin drv_data[i] = 8'h00; pause[i] = 0; end
        forever begin
            @(negedge aclk);
            check_cycle();
            @(posedge aclk);
            cyc++;
            armed    = aresetn ? armed + 1 : 0;
            coll_exp = aresetn ? coll_cond : 1'b0;
            #1;
            drive();
        end
    end

    function automatic bit busy();
        for (int i = 0; i < NUM; i++) if (chq[i].size() > 0) return 1;
        return exp_q.size() != 0;
    endfunction

    task automatic drain(input int max_cyc);
        int n = 0;
        while (busy() && n < max_cyc) begin @(posedge aclk); n++; end
        chk("drain_in_time", {63'd0, n < max_cyc}, 64'd1);
        repeat (2) @(posedge aclk);
    endtask

    task automatic load_frame(input int ch, input logic [7:0] base, input int len);
        for (int b = 0; b < len; b++) chq[ch].push_back('{8'(base + b), b == len - 1});
    endtask

    task automatic clear_logs();
        out_log.delete();
        acc_log.delete();
        coll_seen = 0;
    endtask

    initial begin
        int r0;
        repeat (3) @(posedge aclk);
        #2 aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        // Single 4-beat frame on channel 2.
        clear_logs();
        load_frame(2, 8'hA0, 4);
        drain(100);
        chk("t1_count", 64'(out_log.size()), 64'd4);
        if (out_log.size() == 4 && acc_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t1_data", {56'd0, out_log[k].data}, 64'(8'hA0 + k));
                chk("t1_src", 64'(out_log[k].ch), 64'd2);
                chk("t1_last", {63'd0, out_log[k].last}, {63'd0, k == 3});
                chk("t1_cycle", 64'(out_log[k].cyc), 64'(acc_log[0].cyc + 1 + k));
            end
        end

        // Channels 5 and 1 contend in IDLE.
        clear_logs();
        load_frame(5, 8'h50, 3);
        load_frame(1, 8'h10, 3);
        drain(100);
        chk("t2_count", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            chk("t2_first_ch", 64'(out_log[0].ch), 64'd1);
            chk("t2_ch1_end", {55'd0, out_log[2].last, out_log[2].data}, {55'd0, 1'b1, 8'h12});
            chk("t2_ch5_start", 64'(out_log[3].ch), 64'd5);
            chk("t2_ch5_end", {56'd0, out_log[5].data}, 64'h52);
        end
`ifdef AXIS_ORTHO_MERGE_COLLISION_EN
        chk("t2_collision_seen", {63'd0, coll_seen > 0}, 64'd1);
`else
        chk("t2_collision_tied", 64'(coll_seen), 64'd0);
`endif

        // Channel 3 stalls mid-frame while channel 0 waits.
        clear_logs();
        load_frame(3, 8'h30, 4);
        r0 = 0;
        while (acc_log.size() < 2 && r0 < 50) begin @(negedge aclk); r0++; end
        pause[3] = 1;
        load_frame(0, 8'h01, 2);
        r0 = 0;
        repeat (10) begin @(negedge aclk); if (mon_ready[0]) r0++; end
        chk("t3_ch0_blocked", 64'(r0), 64'd0);
        pause[3] = 0;
        drain(100);
        chk("t3_count", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            chk("t3_ch3_end", {55'd0, out_log[3].last, out_log[3].data}, {55'd0, 1'b1, 8'h33});
            chk("t3_ch0_after", 64'(out_log[4].ch), 64'd0);
        end

        // 1000 beats from rotating channels under random backpressure.
        clear_logs();
        rand_ready = 1;
        for (int f = 0; f < 250; f++) load_frame(f % NUM, 8'(f * 4), 4);
        drain(20000);
        chk("t4_count", 64'(out_log.size()), 64'd1000);
        rand_ready = 0;

        // Back-to-back single-beat frames on channel 7.
        clear_logs();
        for (int k = 0; k < 8; k++) chq[7].push_back('{8'(8'h70 + k), 1'b1});
        drain(100);
        chk("t5_count", 64'(out_log.size()), 64'd8);
        if (out_log.size() == 8) begin
            chk("t5_span", 64'(out_log[7].cyc - out_log[0].cyc), 64'd7);
            chk("t5_src", 64'(out_log[7].ch), 64'd7);
        end

        // Reset during the third beat of a 6-beat frame.
        clear_logs();
        load_frame(3, 8'hC0, 6);
        r0 = 0;
        while (acc_log.size() < 3 && r0 < 50) begin @(negedge aclk); r0++; end
        #2 aresetn = 1'b0;
        for (int i = 0; i < NUM; i++) chq[i].delete();
        #1 chk("t6_tvalid_in_reset", {63'd0, m_if.axis_tvalid}, 64'd0);
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b1;
        clear_logs();
        load_frame(4, 8'hD0, 3);
        drain(100);
        chk("t6_count", 64'(out_log.size()), 64'd3);
        if (out_log.size() == 3) begin
            chk("t6_src", 64'(out_log[0].ch), 64'd4);
            chk("t6_data", {56'd0, out_log[0].data}, 64'hD0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
